// File: rtl/meas_sequencer.sv
// Measurement-batch sequencer for the DSP time-of-arrival processor.
// Runs 2^NAVG_LOG2 settle/run measurements, accumulates hits and reports the batch average.
module meas_sequencer #(
    parameter int TIM_W     = 14,
    parameter int NAVG_LOG2 = 2,
    parameter int WINDOW    = 4096,
    parameter int SETTLE    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic signed [TIM_W-1:0] dsp_tim,
    input  logic                    dsp_rdy,
    output logic                    dsp_ena,
    output logic                    dsp_rst,
    output logic                    busy,
    output logic                    done,
    output logic signed [TIM_W-1:0] result,
    output logic [NAVG_LOG2:0]      hits,
    output logic                    timeout
);
    localparam int NMEAS = 2 ** NAVG_LOG2;
    localparam int ACC_W = TIM_W + NAVG_LOG2;
    localparam int CNT_W = NAVG_LOG2 + 1;
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t                    state_r, state_s;
    logic [SET_W-1:0]          settle_cnt_r, settle_cnt_s;
    logic [WIN_W-1:0]          win_cnt_r, win_cnt_s;
    logic [CNT_W-1:0]          meas_cnt_r, meas_cnt_s;
    logic [CNT_W-1:0]          hit_cnt_r, hit_cnt_s;
    logic signed [ACC_W-1:0]   acc_r, acc_s;
    logic signed [TIM_W-1:0]   result_r, result_s;
    logic [CNT_W-1:0]          hits_r, hits_s;
    logic                      timeout_r, timeout_s;
    logic signed [ACC_W-1:0]   tim_ext_s, acc_sum_s;

    assign tim_ext_s = {{NAVG_LOG2{dsp_tim[TIM_W-1]}}, dsp_tim};
    assign acc_sum_s = acc_r + tim_ext_s;

    // Next-state and datapath update for the batch sequencer
    always_comb begin
        state_s      = state_r;
        settle_cnt_s = settle_cnt_r;
        win_cnt_s    = win_cnt_r;
        meas_cnt_s   = meas_cnt_r;
        hit_cnt_s    = hit_cnt_r;
        acc_s        = acc_r;
        result_s     = result_r;
        hits_s       = hits_r;
        timeout_s    = timeout_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_s      = ST_SETTLE;
                    settle_cnt_s = {SET_W{1'b0}};
                    meas_cnt_s   = {CNT_W{1'b0}};
                    hit_cnt_s    = {CNT_W{1'b0}};
                    acc_s        = {ACC_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_r == SET_W'(SETTLE - 1)) begin
                    state_s   = ST_RUN;
                    win_cnt_s = {WIN_W{1'b0}};
                end else begin
                    settle_cnt_s = settle_cnt_r + SET_W'(1);
                end
            end
            ST_RUN: begin
                if (dsp_rdy || (win_cnt_r == WIN_W'(WINDOW - 1))) begin
                    meas_cnt_s   = meas_cnt_r + CNT_W'(1);
                    settle_cnt_s = {SET_W{1'b0}};
                    // A ready on the last window cycle still counts as a hit
                    if (dsp_rdy) begin
                        acc_s     = acc_sum_s;
                        hit_cnt_s = hit_cnt_r + CNT_W'(1);
                    end else begin
                        acc_s     = acc_r;
                        hit_cnt_s = hit_cnt_r;
                    end
                    if (meas_cnt_r == CNT_W'(NMEAS - 1)) begin
                        state_s = ST_FINISH;
                        hits_s  = hit_cnt_s;
                        if (hit_cnt_s == CNT_W'(NMEAS)) begin
                            result_s  = acc_s[ACC_W-1:NAVG_LOG2];
                            timeout_s = 1'b0;
                        end else begin
                            result_s  = {TIM_W{1'b0}};
                            timeout_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_SETTLE;
                    end
                end else begin
                    win_cnt_s = win_cnt_r + WIN_W'(1);
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Abort discards the batch, including any result staged this cycle
        if (abort) begin
            state_s   = ST_IDLE;
            result_s  = result_r;
            hits_s    = hits_r;
            timeout_s = timeout_r;
        end else begin
            state_s = state_s;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= {SET_W{1'b0}};
            win_cnt_r    <= {WIN_W{1'b0}};
            meas_cnt_r   <= {CNT_W{1'b0}};
            hit_cnt_r    <= {CNT_W{1'b0}};
            acc_r        <= {ACC_W{1'b0}};
            result_r     <= {TIM_W{1'b0}};
            hits_r       <= {CNT_W{1'b0}};
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            settle_cnt_r <= settle_cnt_s;
            win_cnt_r    <= win_cnt_s;
            meas_cnt_r   <= meas_cnt_s;
            hit_cnt_r    <= hit_cnt_s;
            acc_r        <= acc_s;
            result_r     <= result_s;
            hits_r       <= hits_s;
            timeout_r    <= timeout_s;
        end
    end

    assign dsp_ena = (state_r == ST_RUN);
    assign dsp_rst = (state_r == ST_RUN);
    assign busy    = (state_r != ST_IDLE);
    assign done    = (state_r == ST_FINISH);
    assign result  = result_r;
    assign hits    = hits_r;
    assign timeout = timeout_r;
endmodule

// File: tb/tb_meas_sequencer.sv
// Directed self-checking bench for meas_sequencer (WINDOW=64, NAVG_LOG2=2, SETTLE=4).
module tb_meas_sequencer;
    logic               clk;
    logic               rst;
    logic               start;
    logic               abort;
    logic signed [13:0] dsp_tim;
    logic               dsp_rdy;
    logic               dsp_ena;
    logic               dsp_rst;
    logic               busy;
    logic               done;
    logic signed [13:0] result;
    logic [2:0]         hits;
    logic               timeout;

    int n_cmp;
    int n_err;

    meas_sequencer #(
        .TIM_W(14), .NAVG_LOG2(2), .WINDOW(64), .SETTLE(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dsp_tim(dsp_tim), .dsp_rdy(dsp_rdy),
        .dsp_ena(dsp_ena), .dsp_rst(dsp_rst), .busy(busy), .done(done),
        .result(result), .hits(hits), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One batch: r<0 means no ready (miss); ab>=0 aborts that measurement on RUN cycle 20.
    task automatic run_batch(input int t0, input int t1, input int t2, input int t3,
                             input int r0, input int r1, input int r2, input int r3,
                             input int ab, input int er, input int eh, input int et);
        int tv[4];
        int rv[4];
        tv = '{t0, t1, t2, t3};
        rv = '{r0, r1, r2, r3};
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 4; s++) begin
                chk("settle_ena", dsp_ena, 0);
                chk("settle_rst", dsp_rst, 0);
                start   = (i == 1 && s == 1) ? 1'b1 : 1'b0;
                dsp_rdy = (s == 2) ? 1'b1 : 1'b0;
                dsp_tim = 14'sd1000;
                step();
            end
            start = 1'b0;
            chk("run_ena", dsp_ena, 1);
            chk("run_rst", dsp_rst, 1);
            if (i == ab) begin
                repeat (20) step();
                chk("ena_before_abort", dsp_ena, 1);
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_ena", dsp_ena, 0);
                chk("abort_rst", dsp_rst, 0);
                chk("abort_done", done, 0);
                break;
            end
            if (rv[i] < 0) begin
                repeat (63) step();
                chk("miss_run_cycle63", dsp_ena, 1);
                step();
                chk("miss_run_end", dsp_ena, 0);
            end else begin
                repeat (rv[i]) step();
                chk("hit_run_live", dsp_ena, 1);
                dsp_rdy = 1'b1;
                dsp_tim = tv[i][13:0];
                step();
                dsp_rdy = 1'b0;
                dsp_tim = 14'($urandom);
                chk("hit_run_end", dsp_ena, 0);
            end
        end
        if (ab < 0) begin
            chk("done_pulse", done, 1);
            chk("finish_busy", busy, 1);
        end
        chk("result", result, er);
        chk("hits", hits, eh);
        chk("timeout", timeout, et);
        if (ab < 0) begin
            start = 1'b1;
            step();
            start = 1'b0;
            chk("done_one_cycle", done, 0);
            chk("idle_after_finish", busy, 0);
        end
        repeat (2) step();
        chk("no_extra_batch_busy", busy, 0);
        chk("no_extra_batch_done", done, 0);
        chk("held_result", result, er);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        dsp_rdy = 1'b0;
        dsp_tim = 14'sd0;

        // Reset with random inputs
        for (int k = 0; k < 3; k++) begin
            start   = 1'($urandom);
            abort   = 1'($urandom);
            dsp_rdy = 1'($urandom);
            dsp_tim = 14'($urandom);
            step();
            chk("rst_ena", dsp_ena, 0);
            chk("rst_dsprst", dsp_rst, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_result", result, 0);
            chk("rst_hits", hits, 0);
            chk("rst_timeout", timeout, 0);
        end
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        dsp_rdy = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_wins_idle", busy, 0);

        run_batch(100, 102, 98, 104, 10, 10, 10, 10, -1, 101, 4, 0);
        run_batch(-10, -11, -10, -11, 10, 10, 10, 10, -1, -11, 4, 0);
        run_batch(50, 0, 50, 50, 10, -1, 10, 10, -1, 0, 3, 1);
        run_batch(50, 50, 50, 50, 10, 63, 10, 10, -1, 50, 4, 0);
        run_batch(7, 7, 7, 7, 10, 10, 10, 10, 2, 50, 4, 0);
        chk("abort_keeps_hits", hits, 4);
        chk("abort_keeps_timeout", timeout, 0);

        // Back-to-back: start held, ready held -> 22-cycle batch period
        start   = 1'b1;
        dsp_rdy = 1'b1;
        dsp_tim = 14'sd20;
        for (int k = 1; k <= 66; k++) begin
            step();
            chk("b2b_busy", busy, ((k % 22) != 0) ? 1 : 0);
            chk("b2b_done", done, ((k % 22) == 21) ? 1 : 0);
            if ((k % 22) == 21) begin
                chk("b2b_result", result, 20);
            end else begin
                chk("b2b_ena_or_idle", dsp_ena & ~busy, 0);
            end
        end
        start   = 1'b0;
        dsp_rdy = 1'b0;
        step();
        chk("b2b_stop", busy, 0);

        // Reset in the middle of a run clears everything
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("mid_run_ena", dsp_ena, 1);
        rst = 1'b0;
        step();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ena", dsp_ena, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_hits", hits, 0);
        chk("mid_rst_timeout", timeout, 0);
        rst = 1'b1;
        step();
        chk("post_rst_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/meas_sequencer.md
Name: meas_sequencer

Overview:
- Control block that runs one measurement batch on the DSP processor (correlator, timer, detector, output stage).
- Per batch: 2^NAVG_LOG2 measurements, each a reset/settle interval then an enable window.
- Captures each reported time-of-arrival on dsp_rdy, counts hits and misses, reports the batch average with a done pulse.
- Sits between the host/control logic and the DSP processor's ena/rst/tim/rdy pins.

Parameters:
- TIM_W, 14: width of signed time value from DSP processor.
- NAVG_LOG2, 2: log2 of measurements per batch (default 4).
- WINDOW, 4096: maximum RUN cycles per measurement before declaring a miss.
- SETTLE, 4: cycles DSP is held in reset (dsp_rst=0, dsp_ena=0) before each RUN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- start  in  1  batch request, sampled only in IDLE
- abort  in  1  cancel current batch, any state
- dsp_tim  in  TIM_W signed  time value from DSP processor
- dsp_rdy  in  1  DSP processor result-ready strobe
- dsp_ena  out  1  enable to DSP processor
- dsp_rst  out  1  active-low reset to DSP processor
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, batch complete
- result  out  TIM_W signed  batch average
- hits  out  NAVG_LOG2+1  number of measurements that produced dsp_rdy
- timeout  out  1  at least one measurement missed in last batch

Behaviour:
- Interface: one clock clk; rst synchronous, active-low.
- Reset (rst=0 at a clk edge), all registers cleared:
  - state=IDLE, dsp_ena=0, dsp_rst=0, busy=0, done=0
  - result=0, hits=0, timeout=0, accumulator=0, counters=0
- Outputs decode from registered state/flags only; no combinational input-to-output path.
- States:
  - IDLE: dsp_ena=0, dsp_rst=0 (DSP held in reset). start=1 -> clear accumulator, hit count and measurement count -> SETTLE.
  - SETTLE: dsp_ena=0, dsp_rst=0, lasts exactly SETTLE cycles -> RUN.
  - RUN: dsp_ena=1, dsp_rst=1; window counter starts at 0, increments each RUN cycle.
    - dsp_rdy=1 -> add sign-extended dsp_tim to accumulator (width TIM_W+NAVG_LOG2), increment hit count, end measurement.
    - Window counter==WINDOW-1 with dsp_rdy=0 -> miss, end measurement. RUN never exceeds WINDOW cycles.
    - dsp_rdy=1 on cycle WINDOW-1 -> hit (hit wins over expiry).
    - End of measurement: measurement count increments. Count reaches 2^NAVG_LOG2 -> FINISH, else -> SETTLE.
    - dsp_rdy outside RUN is ignored.
  - FINISH: one cycle, done=1, busy=1 -> IDLE.
    - result, hits, timeout registered on entry to FINISH, valid while done=1, held until next FINISH or reset.
    - All measurements hit: result = accumulator >>> NAVG_LOG2 (arithmetic, floor toward -inf), timeout=0.
    - Any miss: result=0, timeout=1; hits still reports the true count.
- Timing: start sampled at edge e0 -> busy=1 and SETTLE from e0. First dsp_ena=1 is the cycle after SETTLE SETTLE cycles. done asserts the cycle after the final RUN cycle.
- start while busy: ignored, not queued. start on the FINISH cycle is ignored; a start held into the following IDLE cycle is accepted.
- abort=1, any non-IDLE state: IDLE at next edge; dsp_ena=0, dsp_rst=0; no done pulse; result/hits/timeout keep previous values.
- abort and start both 1 in IDLE: abort wins, stays IDLE.
- Reset during any state: immediate return to reset values at that edge, including result/hits/timeout.
- Accumulator sized so 2^NAVG_LOG2 full-scale values cannot overflow (TIM_W+NAVG_LOG2 bits).

Test Plan:
Bench parameters: WINDOW=64, NAVG_LOG2=2, SETTLE=4.
- Reset: rst=0 for 3 cycles, random inputs -> dsp_ena=0, dsp_rst=0, busy=0, done=0, result=0, hits=0, timeout=0.
- Four hits:
  - Stimulus: dsp_tim=100, 102, 98, 104 with dsp_rdy on RUN cycle 10 of each window.
  - Required: result=101, hits=4, timeout=0, done high exactly one cycle; dsp_ena first high 5th cycle after start edge; 4 cycles dsp_rst=0 between RUNs.
- Negative values: dsp_tim=-10, -11, -10, -11 -> sum -42, result=-11 (floor), hits=4, timeout=0.
- Miss:
  - Stimulus: no dsp_rdy in measurement 2; others dsp_tim=50.
  - Required: measurement 2 RUN lasts exactly 64 cycles; final result=0, hits=3, timeout=1.
  - Variant: dsp_rdy on window cycle 63 -> counted as hit, hits=4.
- Abort: abort=1 on RUN cycle 20 of measurement 3 -> next cycle state IDLE, dsp_ena=0, busy=0, no done; result/hits from previous batch unchanged. start pulses during busy produce no extra batch.
- Back-to-back: start held high continuously -> batches repeat, IDLE lasts one cycle between FINISH and SETTLE; each batch produces exactly one done.
